// File: rtl/decoder_3to8_buf_pkg.sv
// Shared definitions for the buffered 3-to-8 decoder: widths, occupancy
// state encodings and the code-to-one-hot decode function.
package dec_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // An encoder that saw no input bit set sends zero=1, which decodes to all-zero.
  function automatic logic [ONEHOT_W-1:0] code2onehot(input logic [CODE_W-1:0] code,
                                                      input logic              zero);
    return zero ? '0 : (ONEHOT_W'(1) << code);
  endfunction

endpackage

// File: rtl/decoder_3to8_buf_if.sv
// Upstream code handshake and downstream one-hot handshake of the decoder.
// The decoder takes the slave modport; its driver/consumer takes master.
interface decoder_3to8_buf_if;
  import dec_pkg::*;

  logic [CODE_W-1:0]   in_code;
  logic                in_zero;
  logic                in_valid;
  logic                in_ready;
  logic [ONEHOT_W-1:0] out_onehot;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_code, in_zero, in_valid, out_ready,
    input  in_ready, out_onehot, out_valid
  );

  modport slave (
    input  in_code, in_zero, in_valid, out_ready,
    output in_ready, out_onehot, out_valid
  );

endinterface

// File: rtl/decoder_3to8_buf_fifo2.sv
// Two-entry FIFO of decoded one-hot words with a registered occupancy FSM.
// Ready/valid are decoded from the state register only.
module dec_fifo2
  import dec_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ONEHOT_W-1:0] wr_data_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  output logic [ONEHOT_W-1:0] rd_data_o,
  output logic                rd_valid_o,
  input  logic                rd_ready_i
);

  logic [1:0]          state_q, state_d;
  logic                wr_ptr_q, rd_ptr_q;
  logic [ONEHOT_W-1:0] mem_q [DEPTH];
  logic                push, pop;

  assign wr_ready_o = (state_q != ST_FULL);
  assign rd_valid_o = (state_q != ST_EMPTY);
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;

  assign push = wr_valid_i && wr_ready_o;
  assign pop  = rd_valid_o && rd_ready_i;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // NOTE: non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: storage is not reset; the output mux masks it while EMPTY.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/decoder_3to8_buf.sv
// Buffered 3-to-8 one-hot decoder: decodes at push time into a 2-entry FIFO.
// Define DEC_ZERO_CNT_EN to build the saturating count of accepted zero beats.
module decoder_3to8_buf
  import dec_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  decoder_3to8_buf_if.slave      bus,
  output logic [CNT_W-1:0]       zero_cnt
);

  logic [ONEHOT_W-1:0] wr_word;

  assign wr_word = code2onehot(bus.in_code, bus.in_zero);

  dec_fifo2 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data_i  (wr_word),
    .wr_valid_i (bus.in_valid),
    .wr_ready_o (bus.in_ready),
    .rd_data_o  (bus.out_onehot),
    .rd_valid_o (bus.out_valid),
    .rd_ready_i (bus.out_ready)
  );

`ifdef DEC_ZERO_CNT_EN
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

  // Saturates at all-ones; only reset clears it.
  always_comb begin
    zero_cnt_d = zero_cnt_q;
    if (bus.in_valid && bus.in_ready && bus.in_zero && (zero_cnt_q != '1))
      zero_cnt_d = zero_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_cnt_q <= '0;
    else        zero_cnt_q <= zero_cnt_d;
  end

  assign zero_cnt = zero_cnt_q;
`else
  assign zero_cnt = '0;
`endif

endmodule

// File: tb/tb_decoder_3to8_buf.sv
// Directed self-checking bench for decoder_3to8_buf; expectations adapt to
// whether DEC_ZERO_CNT_EN is defined.
module tb_decoder_3to8_buf;

`ifdef DEC_ZERO_CNT_EN
  localparam bit ZC_EN = 1'b1;
`else
  localparam bit ZC_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] zero_cnt;
  int         n_vec;
  int         n_err;

  decoder_3to8_buf_if dut_if ();

  decoder_3to8_buf #(
    .DEPTH (2),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (dut_if.slave),
    .zero_cnt (zero_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] code, input logic zero, input logic rdy);
    dut_if.in_valid  = v;
    dut_if.in_code   = code;
    dut_if.in_zero   = zero;
    dut_if.out_ready = rdy;
  endtask

  logic [7:0] stream_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    check("rst_out_valid",  32'(dut_if.out_valid),  32'h0);
    check("rst_out_onehot", 32'(dut_if.out_onehot), 32'h00);
    check("rst_in_ready",   32'(dut_if.in_ready),   32'h1);
    check("rst_zero_cnt",   32'(zero_cnt),          32'h0);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Streaming codes 0..7 back-to-back with out_ready high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b0, 1'b1);
      step();
      check($sformatf("stream_onehot_%0d", i), 32'(dut_if.out_onehot), 32'(stream_exp[i]));
      check($sformatf("stream_valid_%0d", i),  32'(dut_if.out_valid),  32'h1);
      check($sformatf("stream_ready_%0d", i),  32'(dut_if.in_ready),   32'h1);
    end
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    step();
    check("stream_drain_valid", 32'(dut_if.out_valid), 32'h0);

    // Back-pressure: 3 and 5 fill the buffer, 6 is held off
    drive(1'b1, 3'd3, 1'b0, 1'b0);
    step();
    check("bp_ready_after_1", 32'(dut_if.in_ready),   32'h1);
    check("bp_head_after_1",  32'(dut_if.out_onehot), 32'h08);
    drive(1'b1, 3'd5, 1'b0, 1'b0);
    step();
    check("bp_ready_after_2", 32'(dut_if.in_ready),   32'h0);
    drive(1'b1, 3'd6, 1'b0, 1'b0);
    step();
    check("bp_held_ready", 32'(dut_if.in_ready),   32'h0);
    check("bp_held_head",  32'(dut_if.out_onehot), 32'h08);
    drive(1'b1, 3'd6, 1'b0, 1'b1);
    step();
    check("bp_pop1_head",  32'(dut_if.out_onehot), 32'h20);
    check("bp_pop1_ready", 32'(dut_if.in_ready),   32'h1);
    step();
    check("bp_pop2_head",  32'(dut_if.out_onehot), 32'h40);
    check("bp_pop2_valid", 32'(dut_if.out_valid),  32'h1);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    step();
    check("bp_drain_valid", 32'(dut_if.out_valid), 32'h0);

    // Zero flag beat
    drive(1'b1, 3'd7, 1'b1, 1'b0);
    step();
    check("zero_valid",  32'(dut_if.out_valid),  32'h1);
    check("zero_onehot", 32'(dut_if.out_onehot), 32'h00);
    check("zero_cnt_1",  32'(zero_cnt),          ZC_EN ? 32'h1 : 32'h0);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    step();
    check("zero_drain_valid", 32'(dut_if.out_valid), 32'h0);

    // Fill to FULL, then asynchronous reset between edges
    drive(1'b1, 3'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'd4, 1'b0, 1'b0);
    step();
    check("mid_full_ready", 32'(dut_if.in_ready), 32'h0);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  32'(dut_if.out_valid),  32'h0);
    check("mid_rst_onehot", 32'(dut_if.out_onehot), 32'h00);
    check("mid_rst_ready",  32'(dut_if.in_ready),   32'h1);
    check("mid_rst_cnt",    32'(zero_cnt),          32'h0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_idle_valid", 32'(dut_if.out_valid), 32'h0);
    drive(1'b1, 3'd2, 1'b0, 1'b1);
    step();
    check("post_rst_first", 32'(dut_if.out_onehot), 32'h04);
    check("post_rst_valid", 32'(dut_if.out_valid),  32'h1);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    step();

    // Saturation: 300 accepted zero beats
    for (int i = 1; i <= 300; i++) begin
      drive(1'b1, 3'd0, 1'b1, 1'b1);
      step();
      if (i == 254) check("sat_cnt_254", 32'(zero_cnt), ZC_EN ? 32'd254 : 32'd0);
      if (i == 255) check("sat_cnt_255", 32'(zero_cnt), ZC_EN ? 32'd255 : 32'd0);
    end
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    step();
    check("sat_cnt_300",   32'(zero_cnt),          ZC_EN ? 32'd255 : 32'd0);
    check("sat_out_valid", 32'(dut_if.out_valid),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_buf.md
# decoder_3to8_buf

Buffered 3-to-8 one-hot decoder. It is the receive-side counterpart of the 8:3 priority encoder. It accepts a 3-bit code plus a "no bit set" flag over a valid/ready handshake, stores it in a 2-entry buffer, and presents the registered one-hot word downstream over a second valid/ready handshake. It sits directly behind an encoder link so that back-pressure from the consumer never drops a code.

## Interface
Parameters:
- `DEPTH`, default 2. Buffer entries; fixed at 2, and only 2 is supported.
- `CNT_W`, default 8. Width of the zero-code counter (only used with `DEC_ZERO_CNT_EN`).

Ports:
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `in_code`  in  3  Binary code from the encoder.
- `in_zero`  in  1  1 means the encoder saw no input bit set, so the decoded word is all-zero.
- `in_valid`  in  1  Input beat is offered.
- `in_ready`  out  1  Buffer can accept a beat.
- `out_onehot`  out  8  Decoded word; bit `in_code` is set, or all zero if `in_zero` is 1.
- `out_valid`  out  1  `out_onehot` holds a beat.
- `out_ready`  in  1  Consumer takes the beat.
- `zero_cnt`  out  `CNT_W`  Saturating count of accepted `in_zero` beats (only with `DEC_ZERO_CNT_EN`).

## Operation
- Accept rule: a beat is accepted on a rising edge where `in_valid && in_ready`.
- Pop rule: a beat is popped on a rising edge where `out_valid && out_ready`.
- Decode happens at push time, and the buffer stores 8-bit one-hot words:
  - word = `in_zero ? 8'h00 : (8'h01 << in_code)`.
- Occupancy state machine (registered):
  - EMPTY → ONE on accept.
  - ONE → FULL on accept without pop.
  - ONE → EMPTY on pop without accept.
  - ONE → ONE on simultaneous accept and pop.
  - FULL → ONE on pop. FULL never accepts.
- Outputs by state:
  - `in_ready` = (state != FULL), decoded from the state register only. There is no combinational path from `out_ready`.
  - `out_valid` = (state != EMPTY).
  - `out_onehot` = head entry, and 8'h00 when EMPTY.
- Ordering: strict FIFO order. Read and write pointers are 1 bit each and wrap modulo 2.
- Input holding rules:
  - `in_code` and `in_zero` are don't-care while `in_valid` = 0.
  - The upstream side must hold its beat stable until it is accepted.
- Reset value of every output while `rst_n` = 0:
  - `out_valid` = 0, `out_onehot` = 8'h00, `in_ready` = 1, `zero_cnt` = 0.
  - State is EMPTY and both pointers are 0.
- Reset mid-operation: any buffered beats are discarded immediately (asynchronous). No partial beat appears after reset is released.

## Timing
- Latency: a beat accepted at edge N into EMPTY gives `out_valid` = 1 with its word after edge N (visible during cycle N+1).
- Throughput: 1 beat per cycle sustained while `out_ready` = 1.
- Back-pressure:
  - With `out_ready` = 0, two beats are accepted, then `in_ready` drops after the second accept edge.
  - `in_ready` rises again after the first pop edge.
- Simultaneous accept and pop in ONE: the head advances, and the new beat becomes the head on the next cycle with no bubble.
- All outputs are registered or decoded from registers. There are no input-to-output combinational paths.

## Configuration
- Macro: `DEC_ZERO_CNT_EN`.
- Defined:
  - `zero_cnt` increments by 1 on each accepted beat with `in_zero` = 1.
  - It saturates at 2^`CNT_W`−1 and never wraps.
  - It is cleared only by reset.
- Undefined: the counter logic is absent and `zero_cnt` is tied to 0. All other behaviour is unchanged.

## Structure
- Shared package/header `dec_pkg` holds:
  - `CODE_W` = 3, `ONEHOT_W` = 8.
  - State encodings `ST_EMPTY` = 2'd0, `ST_ONE` = 2'd1, `ST_FULL` = 2'd2.
  - The decode function `code2onehot`.
- One sub-module, `dec_fifo2`: the 2-entry 8-bit FIFO, containing the storage, pointers and occupancy FSM.
- The top level contains the decode logic, instantiates `dec_fifo2`, and holds the optional counter.

## Test plan
- Reset check: hold `rst_n` = 0 with random inputs → `out_valid` = 0, `out_onehot` = 8'h00, `in_ready` = 1, `zero_cnt` = 0.
- Streaming: with `out_ready` = 1, feed codes 0..7 back-to-back → `out_onehot` = 01, 02, 04, 08, 10, 20, 40, 80 on consecutive cycles, each 1 cycle after its accept.
- Back-pressure:
  - With `out_ready` = 0, push codes 3 then 5 → `in_ready` = 0 after the second accept, and a third code (6) is held off.
  - Raise `out_ready` → outputs 08, then 20, then 40, in order with no loss.
- Zero flag: push `in_zero` = 1 with `in_code` = 7 → `out_onehot` = 8'h00 with `out_valid` = 1. With the macro defined, `zero_cnt` goes 0 → 1.
- Reset mid-operation: fill to FULL, then pulse `rst_n` low between edges → outputs clear immediately, and after release the next accepted code 2 yields 8'h04 as the first output.
- Saturation (macro defined, `CNT_W` = 8): push 300 zero beats → `zero_cnt` = 255.
